// File: rtl/lif_neuron_scheduler_if.sv
// Frame-in / spike-vector-out handshake bundle for the LIF neuron scheduler.
// The slave side is the scheduler; the master side feeds frames and drains results.
interface lif_neuron_scheduler_if #(
  parameter int INPUTS  = 16,
  parameter int NEURONS = 4
);
  logic               x_valid;
  logic               x_ready;
  logic [INPUTS-1:0]  x_data;
  logic               spikes_valid;
  logic               spikes_ready;
  logic [NEURONS-1:0] spikes;

  modport slave (
    input  x_valid, x_data, spikes_ready,
    output x_ready, spikes_valid, spikes
  );

  modport master (
    output x_valid, x_data, spikes_ready,
    input  x_ready, spikes_valid, spikes
  );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one combinational LIF core over NEURONS virtual neurons,
// keeping per-neuron weights, membrane potential and last-spike flag locally.
module lif_neuron_scheduler #(
  parameter int N_STAGES         = 4,
  parameter int INPUTS           = 2**N_STAGES,
  parameter int OUTPUT_PRECISION = N_STAGES + 2,
  parameter int NEURONS          = 4,
  parameter int THETA            = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_we,
  input  logic [$clog2(NEURONS)-1:0]    i_cfg_addr,
  input  logic [INPUTS-1:0]             i_cfg_weights,
  input  logic                          i_cfg_glob_we,
  input  logic [2:0]                    i_cfg_shift,
  input  logic [OUTPUT_PRECISION-1:0]   i_cfg_minus_teta,
  input  logic                          i_clear_state,
  output logic                          o_cfg_busy,
  lif_neuron_scheduler_if.slave         s_if,
  output logic [INPUTS-1:0]             o_core_w,
  output logic [INPUTS-1:0]             o_core_x,
  output logic [2:0]                    o_core_shift,
  output logic [OUTPUT_PRECISION-1:0]   o_core_previus_u,
  output logic [OUTPUT_PRECISION-1:0]   o_core_minus_teta,
  output logic                          o_core_was_spike,
  input  logic [OUTPUT_PRECISION-1:0]   i_core_u_out,
  input  logic                          i_core_is_spike
);
  localparam int IDX_W = $clog2(NEURONS);
  localparam logic [OUTPUT_PRECISION-1:0] L_MINUS_THETA = OUTPUT_PRECISION'(-THETA);
  localparam logic [IDX_W-1:0] L_LAST_IDX = IDX_W'(NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic [IDX_W-1:0]              r_idx;
  logic [INPUTS-1:0]             r_x;
  logic [2:0]                    r_shift;
  logic [OUTPUT_PRECISION-1:0]   r_minus_teta;
  logic [NEURONS-1:0]            r_spikes;
  logic [INPUTS-1:0]             r_w_mem  [NEURONS];
  logic [OUTPUT_PRECISION-1:0]   r_u_mem  [NEURONS];
  logic                          r_ws_mem [NEURONS];
  logic                          w_last;
  logic                          w_x_ready;
  logic                          w_spikes_valid;
  logic                          w_busy;

  assign w_last = (r_idx == L_LAST_IDX);

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (s_if.x_valid) w_next_state = S_RUN;
        else              w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next_state = S_OUT;
        else        w_next_state = S_RUN;
      end
      S_OUT: begin
        if (s_if.spikes_ready) w_next_state = S_IDLE;
        else                   w_next_state = S_OUT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // handshake and status decode
  always_comb begin
    w_x_ready      = 1'b0;
    w_spikes_valid = 1'b0;
    w_busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_x_ready = 1'b1;
        w_busy    = 1'b0;
      end
      S_RUN: begin
        w_busy = 1'b1;
      end
      S_OUT: begin
        w_spikes_valid = 1'b1;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // config, frame capture and per-neuron state writeback; config is only honoured while idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx        <= '0;
      r_x          <= '0;
      r_shift      <= 3'd0;
      r_minus_teta <= L_MINUS_THETA;
      r_spikes     <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        r_w_mem[n]  <= '0;
        r_u_mem[n]  <= '0;
        r_ws_mem[n] <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cfg_glob_we) begin
            r_shift      <= i_cfg_shift;
            r_minus_teta <= i_cfg_minus_teta;
          end
          for (int n = 0; n < NEURONS; n++) begin
            if (i_clear_state) begin
              r_u_mem[n]  <= '0;
              r_ws_mem[n] <= 1'b0;
            end
            if (i_cfg_we && (i_cfg_addr == IDX_W'(n))) begin
              r_w_mem[n] <= i_cfg_weights;
            end
          end
          if (s_if.x_valid) begin
            r_x   <= s_if.x_data;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_u_mem[r_idx]  <= i_core_u_out;
          r_ws_mem[r_idx] <= i_core_is_spike;
          r_spikes[r_idx] <= i_core_is_spike;
          if (w_last) r_idx <= '0;
          else        r_idx <= r_idx + IDX_W'(1);
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign s_if.x_ready      = w_x_ready;
  assign s_if.spikes_valid = w_spikes_valid;
  assign s_if.spikes       = r_spikes;
  assign o_cfg_busy        = w_busy;

  // r_idx rests at 0 outside RUN, so the core sees neuron 0 operands there
  assign o_core_w          = r_w_mem[r_idx];
  assign o_core_x          = r_x;
  assign o_core_shift      = r_shift;
  assign o_core_previus_u  = r_u_mem[r_idx];
  assign o_core_minus_teta = r_minus_teta;
  assign o_core_was_spike  = r_ws_mem[r_idx];
endmodule
